// File: rtl/kernel_unit_if.sv
// ALU <-> kernel_unit handshake bundle: operands and start from the ALU,
// busy/done/result/sat back from the filter engine.
interface kernel_unit_if #(
  parameter int bus = 4
);
  logic           start;
  logic [15:0]    cache;
  logic [3:0]     kernelReG;
  logic           busy;
  logic           done;
  logic [bus-1:0] result;
  logic           sat;

  modport master (
    output start, cache, kernelReG,
    input  busy, done, result, sat
  );

  modport slave (
    input  start, cache, kernelReG,
    output busy, done, result, sat
  );
endinterface

// File: rtl/kernel_unit.sv
// Sequential 4-tap MAC filter with normalize, optional rectify and saturation.
// Define KERNEL_ABS_EN to build the rectify stage enabled by kernelReG[3].
module kernel_unit #(
  parameter int bus = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  kernel_unit_if.slave kif
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, NORM} state_t;

  localparam logic signed [17:0] MaxVal = 18'((1 << bus) - 1);

  state_t              state_q, state_d;
  logic [15:0]         cache_q, cache_d;
  logic [1:0]          sel_q, sel_d;
  logic signed [9:0]   acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [bus-1:0]      result_q, result_d;
  logic                sat_q, sat_d;
`ifdef KERNEL_ABS_EN
  logic                abs_q, abs_d;
`endif

  logic [1:0]          tap;
  logic [3:0]          pix;
  logic signed [2:0]   coef;
  logic signed [9:0]   prod;
  logic signed [9:0]   shifted;
  logic signed [9:0]   rect;
  logic signed [17:0]  val_ext;

  // Tap index follows the MAC state so one multiplier serves all four taps.
  always_comb begin
    tap = 2'd0;
    pix = cache_q[3:0];
    case (state_q)
      MAC1: begin tap = 2'd1; pix = cache_q[7:4];   end
      MAC2: begin tap = 2'd2; pix = cache_q[11:8];  end
      MAC3: begin tap = 2'd3; pix = cache_q[15:12]; end
      default: begin tap = 2'd0; pix = cache_q[3:0]; end
    endcase

    coef = 3'sd0;
    case (sel_q)
      2'd0: coef = 3'sd1;
      2'd1: coef = (tap == 2'd0 || tap == 2'd3) ? -3'sd1 : 3'sd3;
      2'd2: coef = (tap == 2'd0 || tap == 2'd3) ? -3'sd1 : 3'sd1;
      default: coef = (tap == 2'd0) ? 3'sd1 : 3'sd0;
    endcase

    prod = $signed({{7{coef[2]}}, coef}) * $signed({6'b0, pix});

    shifted = (sel_q[1] == 1'b0) ? (acc_q >>> 2) : acc_q;
`ifdef KERNEL_ABS_EN
    rect = (abs_q && shifted[9]) ? -shifted : shifted;
`else
    rect = shifted;
`endif
    val_ext = {{8{rect[9]}}, rect};
  end

  always_comb begin
    state_d  = state_q;
    cache_d  = cache_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    result_d = result_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
`ifdef KERNEL_ABS_EN
    abs_d    = abs_q;
`endif
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          cache_d = kif.cache;
          sel_d   = kif.kernelReG[1:0];
`ifdef KERNEL_ABS_EN
          abs_d   = kif.kernelReG[3];
`endif
          acc_d   = '0;
          state_d = MAC0;
        end
      end
      MAC0: begin acc_d = acc_q + prod; state_d = MAC1; end
      MAC1: begin acc_d = acc_q + prod; state_d = MAC2; end
      MAC2: begin acc_d = acc_q + prod; state_d = MAC3; end
      MAC3: begin acc_d = acc_q + prod; state_d = NORM; end
      NORM: begin
        if (val_ext < 0) begin
          result_d = '0;
          sat_d    = 1'b1;
        end else if (val_ext > MaxVal) begin
          result_d = '1;
          sat_d    = 1'b1;
        end else begin
          result_d = val_ext[bus-1:0];
          sat_d    = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cache_q  <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
`ifdef KERNEL_ABS_EN
      abs_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cache_q  <= cache_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sat_q    <= sat_d;
`ifdef KERNEL_ABS_EN
      abs_q    <= abs_d;
`endif
    end
  end

  assign kif.busy   = busy_q;
  assign kif.done   = done_q;
  assign kif.result = result_q;
  assign kif.sat    = sat_q;

endmodule

// File: tb/tb_kernel_unit.sv
// Scoreboard bench for kernel_unit: directed operations push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_kernel_unit;
  localparam int BUS = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   done_seen;
  logic [BUS:0] exp_q[$];

  kernel_unit_if #(.bus(BUS)) dif ();

  kernel_unit #(.bus(BUS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && dif.done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        logic [BUS:0] e;
        e = exp_q.pop_front();
        checkOutput("result", int'(dif.result), int'(e[BUS:1]));
        checkOutput("sat", int'(dif.sat), int'(e[0]));
      end
    end
  end

  // One full operation: accept, scramble inputs, verify busy/done timing.
  task automatic applyStimulus(input logic [15:0] c, input logic [3:0] k,
                               input logic [BUS-1:0] r, input logic s);
    int busy_cnt;
    @(negedge clk);
    dif.start = 1'b1; dif.cache = c; dif.kernelReG = k;
    exp_q.push_back({r, s});
    @(negedge clk);
    dif.start = 1'b0; dif.cache = ~c; dif.kernelReG = ~k;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (dif.busy) busy_cnt++;
      if (dif.done) checkOutput("early_done", 1, 0);
      @(negedge clk);
    end
    checkOutput("busy_cycles", busy_cnt, 5);
    checkOutput("busy_after", int'(dif.busy), 0);
    checkOutput("done_at_k5", int'(dif.done), 1);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(dif.done), 0);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    vectors = 0; miscompares = 0; done_seen = 0;
    dif.start = 1'b0; dif.cache = '0; dif.kernelReG = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(dif.busy), 0);
    checkOutput("reset_done", int'(dif.done), 0);
    checkOutput("reset_result", int'(dif.result), 0);
    checkOutput("reset_sat", int'(dif.sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] box / sharpen / edge");
    applyStimulus(16'h4321, 4'h0, 4'd2, 1'b0);
    applyStimulus(16'h0FF0, 4'h1, 4'd15, 1'b1);
    applyStimulus(16'hFFFF, 4'h1, 4'd15, 1'b0);
    applyStimulus(16'h3001, 4'h2, 4'd0, 1'b1);
`ifdef KERNEL_ABS_EN
    applyStimulus(16'h3001, 4'hA, 4'd4, 1'b0);
`else
    applyStimulus(16'h3001, 4'hA, 4'd0, 1'b1);
`endif
    applyStimulus(16'hF00C, 4'h3, 4'd12, 1'b0);

    $display("[TB] busy rejection");
    base = done_seen;
    @(negedge clk);
    dif.start = 1'b1; dif.cache = 16'h000A; dif.kernelReG = 4'h3;
    exp_q.push_back({4'd10, 1'b0});
    @(negedge clk); dif.start = 1'b0;
    @(negedge clk); dif.start = 1'b1; dif.cache = 16'h0005;
    @(negedge clk); dif.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reject_done_k5", int'(dif.done), 1);
    repeat (8) @(negedge clk);
    checkOutput("reject_done_count", done_seen - base, 1);

    $display("[TB] back-to-back");
    base = done_seen;
    @(negedge clk);
    dif.start = 1'b1; dif.cache = 16'h0007; dif.kernelReG = 4'h3;
    repeat (3) exp_q.push_back({4'd7, 1'b0});
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (dif.done) checkOutput("b2b_done_cycle",
                                (cyc == 5 || cyc == 11 || cyc == 17) ? 1 : 0, 1);
    end
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_done_count", done_seen - base, 3);

    $display("[TB] reset mid-operation");
    base = done_seen;
    @(negedge clk);
    dif.start = 1'b1; dif.cache = 16'h4321; dif.kernelReG = 4'h0;
    @(negedge clk); dif.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(dif.busy), 0);
    checkOutput("midrst_done", int'(dif.done), 0);
    checkOutput("midrst_result", int'(dif.result), 0);
    checkOutput("midrst_sat", int'(dif.sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("midrst_no_done", done_seen - base, 0);
    applyStimulus(16'h4444, 4'h0, 4'd4, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
